// File: rtl/byte_lane_mem.sv
// rtl/byte_lane_mem.sv - big-endian byte-lane memory with reset-time clear sequencer
// Optional: define MEM_UNALIGNED_EN to let row-crossing accesses complete instead of raising err.
module byte_lane_mem #(
  parameter int LANES    = 4,
  parameter int LANE_W   = 8,
  parameter int ROW_LOG2 = 10,
  localparam int LG      = $clog2(LANES),
  localparam int ADDR_W  = ROW_LOG2 + LG,
  localparam int DW      = LANES * LANE_W,
  localparam int LEN_W   = LG + 1,
  localparam int ROWS    = 1 << ROW_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DW-1:0]     wdata,
  input  logic              memread,
  input  logic              memwrite,
  output logic              ready,
  output logic [DW-1:0]     rdata,
  output logic              rvalid,
  output logic              err
);

  typedef enum logic {INIT, IDLE} state_t;

  state_t              state_q, state_d;
  logic [ROW_LOG2-1:0] row_cnt_q, row_cnt_d;

  logic [LANE_W-1:0]   mem_q [LANES][ROWS];

  logic [LEN_W-1:0]    len_eff;
  logic [LG-1:0]       base_bank;
  logic [ROW_LOG2-1:0] base_row;
  logic                reject;
  logic                accept, do_write, do_read;

  logic [LG-1:0]       k_b     [LANES];
  logic [LG-1:0]       lane_b  [LANES];
  logic [ROW_LOG2-1:0] row_b   [LANES];
  logic [LANE_W-1:0]   wbyte_b [LANES];
  logic [LANES-1:0]    en_b;

  logic                rd_pend_q;
  logic [LANES-1:0]    rd_en_q;
  logic [LG-1:0]       rd_lane_q [LANES];
  logic [LANE_W-1:0]   rd_byte_q [LANES];
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                rvalid_q;
  logic                err_q, err_d;

  assign base_bank = addr[LG-1:0];
  assign base_row  = addr[ADDR_W-1:LG];

  always_comb begin
    len_eff = len;
    if (len == '0 || len > LEN_W'(LANES)) len_eff = LEN_W'(LANES);
  end

`ifdef MEM_UNALIGNED_EN
  assign reject = 1'b0;
`else
  logic [LEN_W:0] span;
  assign span   = (LEN_W+1)'(base_bank) + (LEN_W+1)'(len_eff);
  assign reject = span > (LEN_W+1)'(LANES);
`endif

  assign accept   = rst_n && (state_q == IDLE) && (memread || memwrite);
  assign do_write = accept && memwrite && !reject;
  assign do_read  = accept && memread && !memwrite && !reject;
  assign err_d    = accept && reject;

  // Bank b holds access byte k = (b - base_bank) mod LANES; banks below base_bank sit one row up.
  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      k_b[b]     = LG'(b) - base_bank;
      en_b[b]    = LEN_W'(k_b[b]) < len_eff;
      row_b[b]   = base_row + ROW_LOG2'(LG'(b) < base_bank);
      lane_b[b]  = LG'(len_eff - LEN_W'(1) - LEN_W'(k_b[b]));
      wbyte_b[b] = wdata[int'(lane_b[b])*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      INIT: begin
        row_cnt_d = row_cnt_q + 1'b1;
        if (row_cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    for (int b = 0; b < LANES; b++) begin
      if (rd_en_q[b]) rdata_d[int'(rd_lane_q[b])*LANE_W +: LANE_W] = rd_byte_q[b];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      row_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      rd_pend_q <= do_read;
      rvalid_q  <= rd_pend_q;
      err_q     <= err_d;
      if (rd_pend_q) rdata_q <= rdata_d;
    end
  end

  // Bank arrays carry no reset; the INIT sweep is what zeroes them.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (rst_n && state_q == INIT) begin
        mem_q[b][row_cnt_q] <= '0;
      end else if (do_write && en_b[b]) begin
        mem_q[b][row_b[b]] <= wbyte_b[b];
      end
      if (do_read) begin
        rd_byte_q[b] <= mem_q[b][row_b[b]];
        rd_lane_q[b] <= lane_b[b];
        rd_en_q[b]   <= en_b[b];
      end
    end
  end

  assign ready  = (state_q == IDLE);
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_byte_lane_mem.sv
// tb/tb_byte_lane_mem.sv - scoreboard bench for byte_lane_mem (default parameters)
`timescale 1ns/1ps
module tb_byte_lane_mem;
  localparam int DW     = 32;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DW-1:0]     wdata = '0;
  logic              memread = 1'b0;
  logic              memwrite = 1'b0;
  logic              ready;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic              err;

  byte_lane_mem dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .len(len), .wdata(wdata),
    .memread(memread), .memwrite(memwrite), .ready(ready),
    .rdata(rdata), .rvalid(rvalid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          is_err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic push_rd(input string name, input logic [DW-1:0] d);
    exp_t e;
    e.name = name; e.is_err = 1'b0; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input string name, input logic [DW-1:0] held);
    exp_t e;
    e.name = name; e.is_err = 1'b1; e.data = held;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every rvalid/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rvalid || err) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: rvalid=%b err=%b rdata=%h, required no event", rvalid, err, rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rvalid === e.is_err || err !== e.is_err || rdata !== e.data) begin
          n_fail++;
          $display("FAIL %s: rvalid=%b err=%b rdata=%h, required rvalid=%b err=%b rdata=%h",
                   e.name, rvalid, err, rdata, !e.is_err, e.is_err, e.data);
        end
      end
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [LEN_W-1:0] l, input logic [DW-1:0] wd);
    @(negedge clk);
    addr = a; len = l; wdata = wd; memread = rd; memwrite = wr;
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Counts edges from release until ready; drops any INIT-time read once ready appears.
  task automatic wait_ready(input string name, input int limit);
    int n;
    n = 0;
    while (n < limit) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
    end
    memread = 1'b0;
    check(name, DW'(n), DW'(1024));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", DW'(ready), DW'(0));
    check("reset_rvalid", DW'(rvalid), DW'(0));
    check("reset_err", DW'(err), DW'(0));
    check("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    wait_ready("init_cycles", 2000);

    push_rd("read_after_clear", 32'h0000_0000);
    @(negedge clk);
    addr = 12'h000; len = 3'd4; memread = 1'b1;
    @(negedge clk);
    memread = 1'b0;
    check("latency_edge_n", DW'(rvalid), DW'(0));
    @(negedge clk);
    check("latency_edge_n1", DW'(rvalid), DW'(1));
    repeat (3) @(negedge clk);

    req(0, 1, 12'h010, 3'd4, 32'h1122_3344);
    push_rd("aligned_len2", 32'h0000_2233);
    req(1, 0, 12'h011, 3'd2, '0);
    push_rd("aligned_len1", 32'h0000_0044);
    req(1, 0, 12'h013, 3'd1, '0);

    req(0, 1, 12'h020, 3'd4, 32'hAABB_CCDD);
    req(0, 1, 12'h021, 3'd1, 32'h0000_00EE);
    push_rd("partial_preserve", 32'hAAEE_CCDD);
    req(1, 0, 12'h020, 3'd4, '0);

    push_rd("b2b_first", 32'h1122_3344);
    push_rd("b2b_second", 32'hAAEE_CCDD);
    @(negedge clk);
    addr = 12'h010; len = 3'd4; memread = 1'b1;
    @(negedge clk);
    addr = 12'h020;
    @(negedge clk);
    memread = 1'b0;
    repeat (3) @(negedge clk);

    req(0, 1, 12'h030, 3'd4, 32'h0102_0304);
    req(0, 1, 12'h034, 3'd4, 32'h0506_0708);
`ifdef MEM_UNALIGNED_EN
    push_rd("crossing_read", 32'h0304_0506);
    req(1, 0, 12'h032, 3'd4, '0);
    req(0, 1, 12'hFFF, 3'd2, 32'h0000_BEEF);
    push_rd("wrap_read", 32'h0000_BEEF);
    req(1, 0, 12'hFFF, 3'd2, '0);
    push_rd("wrap_byte_at_0", 32'h0000_00EF);
    req(1, 0, 12'h000, 3'd1, '0);
    push_rd("wrap_byte_at_fff", 32'h0000_00BE);
    req(1, 0, 12'hFFC, 3'd4, '0);
`else
    push_err("crossing_reject", 32'hAAEE_CCDD);
    req(1, 0, 12'h032, 3'd4, '0);
    push_err("wrap_write_reject", 32'hAAEE_CCDD);
    req(0, 1, 12'hFFF, 3'd2, 32'h0000_BEEF);
    push_err("wrap_read_reject", 32'hAAEE_CCDD);
    req(1, 0, 12'hFFF, 3'd2, '0);
    push_rd("no_write_at_0", 32'h0000_0000);
    req(1, 0, 12'h000, 3'd1, '0);
    push_rd("no_write_at_ffc", 32'h0000_0000);
    req(1, 0, 12'hFFC, 3'd4, '0);
`endif

    req(1, 1, 12'h040, 3'd1, 32'h0000_005A);
    push_rd("conflict_write_done", 32'h0000_005A);
    req(1, 0, 12'h040, 3'd1, '0);

    push_rd("len0_full", 32'h1122_3344);
    req(1, 0, 12'h010, 3'd0, '0);
    push_rd("len7_full", 32'hAAEE_CCDD);
    req(1, 0, 12'h020, 3'd7, '0);

    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    addr = 12'h010; len = 3'd4; memread = 1'b1;
    repeat (500) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("mid_init_restart", 2000);
    repeat (3) @(negedge clk);

    push_rd("cleared_010", 32'h0000_0000);
    req(1, 0, 12'h010, 3'd4, '0);
    push_rd("cleared_000", 32'h0000_0000);
    req(1, 0, 12'h000, 3'd4, '0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", DW'(exp_q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
